// File: rtl/block_mover.sv
// Sweeps the current row's block across the playfield in whole-cell steps and,
// on a stop press, trims it to its overlap with the previous row's block.
module block_mover #(
   parameter int FIELD_W  = 320,
   parameter int CELL_W   = 16,
   parameter int TICK_DIV = 1000000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start,
   input  logic       stop_btn,
   input  logic       first_row,
   input  logic [3:0] init_size,
   input  logic [8:0] prev_block_start,
   input  logic [8:0] prev_block_end,
   input  logic [3:0] prev_block_size,
   output logic [8:0] curr_block_start,
   output logic [8:0] curr_block_end,
   output logic [3:0] curr_block_size,
   output logic       stop_true,
   output logic       intersect_true,
   output logic       moving
);

   localparam int         MAX_CELLS = FIELD_W / CELL_W;
   localparam int         CELL_SH   = $clog2(CELL_W);
   localparam int         TW        = $clog2(TICK_DIV);
   localparam logic [9:0] FIELD10   = 10'(FIELD_W);
   localparam logic [9:0] CELL10    = 10'(CELL_W);
   localparam logic [9:0] MAX10     = 10'(MAX_CELLS);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic       DIR_RIGHT = 1'b0;
   localparam logic       DIR_LEFT  = 1'b1;

   typedef enum logic [1:0] {S_IDLE, S_MOVE, S_RESOLVE, S_REPORT} state_t;

   state_t          r_state;
   state_t          w_next_state;
   logic [8:0]      r_start;
   logic [8:0]      r_end;
   logic [3:0]      r_size;
   logic            r_dir;
   logic            r_isect;
   logic [TW-1:0]   r_tick;

   logic [3:0]      w_req_size;
   logic [3:0]      w_load_size;
   logic [9:0]      w_load_width;
   logic            w_accept;
   logic [9:0]      w_width;
   logic [9:0]      w_start10;
   logic            w_wrap;
   logic [9:0]      w_next_start;
   logic            w_next_dir;
   logic [8:0]      w_max_s;
   logic [8:0]      w_min_e;
   logic [8:0]      w_ov_s;
   logic [8:0]      w_ov_e;
   logic            w_isect;
   logic [9:0]      w_ov_len;
   logic [3:0]      w_ov_size;

   // Row load: size source, saturation to the field width, zero-size rejection
   assign w_req_size   = first_row ? init_size : prev_block_size;
   assign w_load_size  = ({6'd0, w_req_size} > MAX10) ? MAX10[3:0] : w_req_size;
   assign w_load_width = {6'd0, w_load_size} << CELL_SH;
   assign w_accept     = (r_state == S_IDLE) && start && (w_load_size != 4'd0);

   assign w_width   = {6'd0, r_size} << CELL_SH;
   assign w_start10 = {1'b0, r_start};
   assign w_wrap    = (r_tick == TICK_LAST);

   // One movement step; the edge cases clamp to the wall and turn around
   always_comb begin
      w_next_start = w_start10;
      w_next_dir   = r_dir;
      if (r_dir == DIR_RIGHT) begin
         if (w_start10 + w_width + CELL10 > FIELD10) begin
            w_next_start = FIELD10 - w_width;
            w_next_dir   = DIR_LEFT;
         end else begin
            w_next_start = w_start10 + CELL10;
         end
      end else begin
         if (w_start10 < CELL10) begin
            w_next_start = 10'd0;
            w_next_dir   = DIR_RIGHT;
         end else begin
            w_next_start = w_start10 - CELL10;
         end
      end
   end

   // Overlap with the previous block; on the first row the whole block survives
   assign w_max_s   = (r_start > prev_block_start) ? r_start : prev_block_start;
   assign w_min_e   = (r_end < prev_block_end) ? r_end : prev_block_end;
   assign w_ov_s    = first_row ? r_start : w_max_s;
   assign w_ov_e    = first_row ? r_end : w_min_e;
   assign w_isect   = (w_ov_s <= w_ov_e);
   assign w_ov_len  = {1'b0, w_ov_e} - {1'b0, w_ov_s} + 10'd1;
   assign w_ov_size = 4'(w_ov_len >> CELL_SH);

   always_ff @(posedge clk) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:    if (w_accept) w_next_state = S_MOVE;
         S_MOVE:    if (stop_btn) w_next_state = S_RESOLVE;
         S_RESOLVE: w_next_state = S_REPORT;
         S_REPORT:  w_next_state = S_IDLE;
         default:   w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      moving         = (r_state == S_MOVE);
      stop_true      = (r_state == S_REPORT);
      intersect_true = (r_state == S_REPORT) && r_isect;
   end

   // Block position/size; a stop on the wrap cycle suppresses that step
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_start <= 9'd0;
         r_end   <= 9'd0;
         r_size  <= 4'd0;
         r_dir   <= DIR_RIGHT;
         r_isect <= 1'b0;
         r_tick  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_start <= 9'd0;
                  r_size  <= w_load_size;
                  r_end   <= 9'(w_load_width - 10'd1);
                  r_dir   <= DIR_RIGHT;
                  r_tick  <= '0;
               end
            end
            S_MOVE: begin
               if (!stop_btn) begin
                  if (w_wrap) begin
                     r_tick  <= '0;
                     r_start <= 9'(w_next_start);
                     r_end   <= 9'(w_next_start + w_width - 10'd1);
                     r_dir   <= w_next_dir;
                  end else begin
                     r_tick <= r_tick + TW'(1);
                  end
               end
            end
            S_RESOLVE: begin
               r_isect <= w_isect;
               if (w_isect) begin
                  r_start <= w_ov_s;
                  r_end   <= w_ov_e;
                  r_size  <= w_ov_size;
               end else begin
                  r_size  <= 4'd0;
               end
            end
            default: ;
         endcase
      end
   end

   assign curr_block_start = r_start;
   assign curr_block_end   = r_end;
   assign curr_block_size  = r_size;

endmodule

// File: tb/tb_block_mover.sv
// Randomised scoreboard bench for block_mover with a behavioural position/overlap model.
module tb_block_mover;

   localparam int FW = 320;
   localparam int CW = 16;
   localparam int TD = 4;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       start = 1'b0;
   logic       stop_btn = 1'b0;
   logic       first_row = 1'b0;
   logic [3:0] init_size = '0;
   logic [8:0] prev_block_start = '0;
   logic [8:0] prev_block_end = '0;
   logic [3:0] prev_block_size = '0;
   logic [8:0] curr_block_start;
   logic [8:0] curr_block_end;
   logic [3:0] curr_block_size;
   logic       stop_true;
   logic       intersect_true;
   logic       moving;

   block_mover #(.FIELD_W(FW), .CELL_W(CW), .TICK_DIV(TD)) dut (
      .clk(clk), .resetn(resetn), .start(start), .stop_btn(stop_btn),
      .first_row(first_row), .init_size(init_size),
      .prev_block_start(prev_block_start), .prev_block_end(prev_block_end),
      .prev_block_size(prev_block_size),
      .curr_block_start(curr_block_start), .curr_block_end(curr_block_end),
      .curr_block_size(curr_block_size), .stop_true(stop_true),
      .intersect_true(intersect_true), .moving(moving)
   );

   always #5 clk = ~clk;

   typedef struct {int s; int e; int sz; int x;} rep_t;
   rep_t q[$];
   rep_t mon_r;
   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Block left edge after k steps of a block of pixel width w, starting at 0 heading right
   function automatic int model_pos(input int w, input int k);
      int p = 0;
      bit right = 1;
      for (int i = 0; i < k; i++) begin
         if (right) begin
            if (p + w + CW > FW) begin p = FW - w; right = 0; end
            else p = p + CW;
         end else begin
            if (p < CW) begin p = 0; right = 1; end
            else p = p - CW;
         end
      end
      return p;
   endfunction

   // Scoreboard monitor: every report must match the oldest expected one
   always @(negedge clk) begin
      if (stop_true) begin
         if (q.size() == 0) begin
            chk("unexpected_stop_true", 1, 0);
         end else begin
            mon_r = q.pop_front();
            chk("rep_start", int'(curr_block_start), mon_r.s);
            chk("rep_end", int'(curr_block_end), mon_r.e);
            chk("rep_size", int'(curr_block_size), mon_r.sz);
            chk("rep_intersect", int'(intersect_true), mon_r.x);
         end
      end
   end

   task automatic run_row(input bit fr, input int isz, input int ps, input int pe,
                          input int psz, input int steps, input bit on_wrap);
      int sz, w, pos, total, os, oe;
      rep_t r;
      first_row        = fr;
      init_size        = 4'(isz);
      prev_block_start = 9'(ps);
      prev_block_end   = 9'(pe);
      prev_block_size  = 4'(psz);
      sz = fr ? isz : psz;
      if (sz > FW / CW) sz = FW / CW;
      w = sz * CW;
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("load_moving", int'(moving), 1);
      chk("load_start", int'(curr_block_start), 0);
      chk("load_end", int'(curr_block_end), w - 1);
      chk("load_size", int'(curr_block_size), sz);
      total = on_wrap ? TD * steps + TD - 1 : TD * steps;
      for (int c = 1; c <= total; c++) begin
         cyc();
         if (c % TD == 0) begin
            pos = model_pos(w, c / TD);
            chk("step_start", int'(curr_block_start), pos);
            chk("step_end", int'(curr_block_end), pos + w - 1);
         end
      end
      pos = model_pos(w, steps);
      if (fr) begin
         r = '{pos, pos + w - 1, sz, 1};
      end else begin
         os = (pos > ps) ? pos : ps;
         oe = (pos + w - 1 < pe) ? pos + w - 1 : pe;
         if (os <= oe) r = '{os, oe, (oe - os + 1) / CW, 1};
         else          r = '{pos, pos + w - 1, 0, 0};
      end
      q.push_back(r);
      stop_btn = 1'b1;
      cyc();
      stop_btn = 1'b0;
      chk("stop_moving", int'(moving), 0);
      chk("resolve_no_report", int'(stop_true), 0);
      cyc();
      chk("report_pulse", int'(stop_true), 1);
      cyc();
      chk("report_drop", int'(stop_true), 0);
      chk("idle_moving", int'(moving), 0);
      chk("hold_start", int'(curr_block_start), r.s);
      chk("hold_size", int'(curr_block_size), r.sz);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int ps, psz, pe;
      resetn = 1'b0;
      cyc();
      cyc();
      chk("rst_start", int'(curr_block_start), 0);
      chk("rst_end", int'(curr_block_end), 0);
      chk("rst_size", int'(curr_block_size), 0);
      chk("rst_stop", int'(stop_true), 0);
      chk("rst_isect", int'(intersect_true), 0);
      chk("rst_moving", int'(moving), 0);
      resetn = 1'b1;
      cyc();
      stop_btn = 1'b1;
      cyc();
      stop_btn = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("idle_stop_ignored", int'(stop_true), 0);
         chk("idle_not_moving", int'(moving), 0);
      end

      // First row: 5 steps of a 3-cell block
      run_row(1, 3, 0, 0, 0, 5, 0);
      // Bounce off both walls
      run_row(1, 3, 0, 0, 0, 37, 0);
      // Partial overlap and a miss
      run_row(0, 0, 64, 127, 4, 6, 0);
      run_row(0, 0, 0, 47, 3, 10, 0);
      // Stop on the tick-wrap cycle resolves the pre-step position
      run_row(1, 2, 0, 0, 0, 3, 1);

      // Reset during MOVE
      first_row = 1'b1;
      init_size = 4'd5;
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 9; i++) cyc();
      resetn = 1'b0;
      cyc();
      chk("midrst_start", int'(curr_block_start), 0);
      chk("midrst_end", int'(curr_block_end), 0);
      chk("midrst_size", int'(curr_block_size), 0);
      chk("midrst_moving", int'(moving), 0);
      resetn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("midrst_no_report", int'(stop_true), 0);
      end

      // Zero-size start is rejected
      init_size = 4'd0;
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("zero_size_idle", int'(moving), 0);
      cyc();
      chk("zero_size_still_idle", int'(moving), 0);
      chk("zero_size_hold", int'(curr_block_size), 0);

      // Randomised back-to-back rows
      for (int n = 0; n < 8; n++) begin
         ps  = CW * $urandom_range(0, 19);
         psz = $urandom_range(1, 15);
         if (psz > 20 - ps / CW) psz = 20 - ps / CW;
         pe  = ps + psz * CW - 1;
         run_row(1'($urandom_range(0, 1)), $urandom_range(1, 15), ps, pe, psz,
                 $urandom_range(0, 25), 1'($urandom_range(0, 1)));
      end

      cyc();
      chk("queue_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
